// File: rtl/fetch_decode_unit_if.sv
// fetch_decode_unit_if: instruction-memory request/response channel between the fetch unit and imem.
interface fetch_decode_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: PC owner, one-at-a-time instruction fetch over valid/ready, field decode.
// Optional FETCH_MISALIGN_TRAP_EN: a retire to a next PC with bit 1 set parks in TRAP and raises misaligned.
module fetch_decode_unit #(
    parameter logic [31:0] RESET_PC    = 32'h01000000,
    parameter int          MEM_LAT_MAX = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    fetch_decode_unit_if.master   imem,
    input  logic                  PCSel,
    input  logic [31:0]           ALU_target,
    input  logic                  retire,
    output logic                  inst_valid,
    output logic [31:0]           PC,
    output logic [31:0]           INST,
    output logic [6:0]            OPCODE,
    output logic [4:0]            RD,
    output logic [4:0]            RS1,
    output logic [4:0]            RS2,
    output logic [2:0]            FUNCT3,
    output logic [6:0]            FUNCT7,
    output logic [4:0]            SHAMT,
    output logic [31:0]           IMM,
    output logic                  timeout
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  misaligned
`endif
);
    localparam int CW = $clog2(MEM_LAT_MAX) + 1;
    localparam logic [CW-1:0] LAT = CW'(MEM_LAT_MAX);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VALID, S_TRAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic [31:0]   npc;
    logic          trap;

    assign npc = PCSel ? (ALU_target & ~32'h1) : PC + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap = npc[1];
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = imem.imem_req_ready ? S_WAIT : S_REQ;
            S_WAIT:  state_d = imem.imem_rsp_valid ? S_VALID : S_WAIT;
            S_VALID: state_d = !retire ? S_VALID : trap ? S_TRAP : S_REQ;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        imem.imem_req_valid = state_q == S_REQ;
        imem.imem_addr      = PC;
        inst_valid          = state_q == S_VALID;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned          = state_q == S_TRAP;
`endif
    end

    // The wait counter saturates at LAT so the sticky flag never depends on wrap-around.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            PC      <= RESET_PC;
            INST    <= NOP;
            timeout <= 1'b0;
            cnt     <= '0;
        end else begin
            if (state_q == S_VALID && retire) PC <= npc;
            if (state_q == S_WAIT && imem.imem_rsp_valid) INST <= imem.imem_rsp_data;
            if (state_q == S_WAIT && cnt == LAT) timeout <= 1'b1;
            cnt <= (state_q != S_WAIT || imem.imem_rsp_valid) ? '0 : (cnt == LAT) ? cnt : cnt + 1'b1;
        end
    end

    assign OPCODE = INST[6:0];
    assign RD     = INST[11:7];
    assign FUNCT3 = INST[14:12];
    assign RS1    = INST[19:15];
    assign RS2    = INST[24:20];
    assign SHAMT  = INST[24:20];
    assign FUNCT7 = INST[31:25];

    always_comb begin
        IMM = '0;
        case (OPCODE)
            7'b0010011, 7'b0000011, 7'b1100111: IMM = {{20{INST[31]}}, INST[31:20]};
            7'b0100011: IMM = {{20{INST[31]}}, INST[31:25], INST[11:7]};
            7'b1100011: IMM = {{19{INST[31]}}, INST[31], INST[7], INST[30:25], INST[11:8], 1'b0};
            7'b0110111, 7'b0010111: IMM = {INST[31:12], 12'b0};
            7'b1101111: IMM = {{11{INST[31]}}, INST[31], INST[19:12], INST[20], INST[30:21], 1'b0};
            default: IMM = '0;
        endcase
    end
endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Front end of the single-cycle datapath: owns the PC register, fetches one instruction at a time from instruction memory over a valid/ready request channel, and splits each word into the decoded fields the control logic consumes (OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM, SHAMT).
- Closes the loop with the control logic: takes back PCSel and the ALU-computed target to pick the next PC when the current instruction retires.

Parameters:
- RESET_PC, 32'h01000000, PC value loaded on reset.
- MEM_LAT_MAX, 16, WAIT-state cycles before the response timeout flag is raised (counter width clog2(MEM_LAT_MAX)+1).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  32  fetch address (= PC); stable while imem_req_valid=1.
- imem_rsp_valid  in  1  instruction word valid.
- imem_rsp_data  in  32  instruction word.
- PCSel  in  1  1: next PC = ALU_target; 0: PC+4. Sampled on retire.
- ALU_target  in  32  branch/jump target from the ALU.
- retire  in  1  downstream has finished the current instruction.
- inst_valid  out  1  decoded fields are valid.
- PC  out  32  PC of the held instruction.
- INST  out  32  raw held instruction.
- OPCODE  out  7  INST[6:0].
- RD  out  5  INST[11:7].
- RS1  out  5  INST[19:15].
- RS2  out  5  INST[24:20].
- FUNCT3  out  3  INST[14:12].
- FUNCT7  out  7  INST[31:25].
- SHAMT  out  5  INST[24:20].
- IMM  out  32  sign-extended immediate.
- timeout  out  1  sticky: WAIT exceeded MEM_LAT_MAX cycles.

Behaviour:
- Reset (reset=0, async): state=IDLE; PC=RESET_PC; INST=32'h00000013 (NOP); inst_valid=0; imem_req_valid=0; timeout=0; wait counter=0. Decoded fields follow INST combinationally.
- States: IDLE -> REQ unconditionally on the first clock after reset deasserts.
- REQ: imem_req_valid=1, imem_addr=PC. On imem_req_ready=1 -> WAIT. imem_rsp_valid is ignored in REQ (responses arrive no earlier than the cycle after acceptance).
- WAIT: imem_req_valid=0; counter increments each cycle. On imem_rsp_valid=1: INST<=imem_rsp_data, counter cleared, -> VALID. When counter reaches MEM_LAT_MAX: timeout<=1 (sticky until reset); the unit keeps waiting.
- VALID: inst_valid=1; INST and PC held. On retire=1: PC<=PCSel ? {ALU_target[31:1],1'b0} : PC+4 (mod 2^32, wraps 32'hFFFFFFFC->0); inst_valid<=0; -> REQ.
- retire outside VALID is ignored; PCSel and ALU_target matter only in the retire cycle.
- IMM by OPCODE: 0010011/0000011/1100111 I-type {20{i[31]},i[31:20]}; 0100011 S {20{i[31]},i[31:25],i[11:7]}; 1100011 B {19{i[31]},i[31],i[7],i[30:25],i[11:8],0}; 0110111/0010111 U {i[31:12],12'b0}; 1101111 J {11{i[31]},i[31],i[19:12],i[20],i[30:21],0}; otherwise 0.
- Latency: retire at cycle t -> imem_req_valid=1 at t+1. With imem_req_ready=1 and a 1-cycle response, inst_valid=1 at t+3.
- Reset mid-WAIT: return to IDLE immediately. Any response arriving afterwards outside WAIT is dropped.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: adds output misaligned (1 bit). If a retire selects a next PC with bit 1 set, PC is still loaded, but the state goes to a TRAP state with no request issued. misaligned=1 and inst_valid=0 in TRAP until reset.
- Undefined: no port; bit 1 is passed through to imem_addr unchecked.

Test Plan:
- Reset release, RESET_PC=32'h01000000, ready=1, 1-cycle response 32'h00500093 -> imem_addr=32'h01000000; inst_valid at cycle 3; OPCODE=7'h13, RD=1, IMM=5.
- Retire with PCSel=0 -> next imem_addr=32'h01000004. Retire with PCSel=1, ALU_target=32'h01000101 -> imem_addr=32'h01000100.
- imem_req_ready held 0 for 4 cycles -> imem_req_valid stays 1 with stable imem_addr; WAIT is entered only on the ready cycle.
- Fetch 32'hFE000EE3 (beq, offset -4) -> IMM=32'hFFFFFFFC. Fetch 32'h123450B7 (lui) -> IMM=32'h12345000.
- No response for MEM_LAT_MAX cycles -> timeout=1. A later response still gives inst_valid=1 and timeout stays 1.
- Reset asserted during WAIT, then a late response -> inst_valid=0; INST=32'h00000013; the new fetch is from RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, retire to ALU_target=32'h01000102 -> misaligned=1; no further imem_req_valid.
